ssd_scan_ctrl: RTL and testbench
================================

Name: ssd_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit common-anode seven-segment display. It sequences the digit select, generates active-low anode enables with an inter-digit blanking gap to prevent ghosting, and presents the current digit's nibble to the segment decoder. A 16-bit display word is double-buffered through a load/ack handshake so updates take effect only on frame boundaries.

Parameters:
ON_CYC, 49744, clock cycles a digit is driven per scan slot (must be >= 1)
BLANK_CYC, 256, clock cycles all anodes are off between digits (0 = no blank phase)
CNT_W, 16, phase counter width; must hold max(ON_CYC, BLANK_CYC) - 1

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous reset, active-high
en  input  1  scan enable; 0 = display dark
data_in  input  16  display word; nibble d drives digit d (digit 0 = bits 3:0, rightmost)
load  input  1  one-cycle request to capture data_in
load_ack  output  1  one-cycle pulse when the pending word is committed to the display register
mask  input  4  per-digit enable; mask[d]=0 keeps digit d dark
control  output  2  current digit index, to the segment path
nibble  output  4  current digit value, to the hex-to-segment decoder
anode  output  4  active-low anode enables (1110 = digit 0 ... 0111 = digit 3, 1111 = all off)
frame_start  output  1  one-cycle pulse at the start of each digit-0 ON slot

Behaviour:
- Reset (RST=1 at a CLK edge): state OFF; control=0, nibble=0, anode=1111, load_ack=0, frame_start=0; display and pending registers = 0; pending_vld=0; phase counter = 0.
- States: OFF, ON, BLANK. All outputs are registered and reflect state and digit one cycle after the transition edge.
- OFF: anode=1111. When en=1, go to ON with digit=0 and raise frame_start.
- ON: anode = one-hot-low of digit if mask[digit]=1, else 1111. After ON_CYC cycles, go to BLANK, or straight to the next ON when BLANK_CYC=0.
- BLANK: anode=1111. After BLANK_CYC cycles, digit <= digit+1 (wraps 3 to 0), then go to ON.
- Frame boundary: entry to ON with digit=0. frame_start pulses for 1 cycle.
- en=0 in any state: next cycle is OFF, digit=0, counter=0, anode=1111. The display register is retained.
- control = digit. nibble = display[4*digit+3 : 4*digit].
- Load handshake:
  - load=1 captures data_in into pending and sets pending_vld.
  - At a frame boundary with pending_vld=1: display <= pending, pending_vld cleared, load_ack pulses in the same cycle as frame_start.
  - In OFF, a pending word commits on the next cycle and load_ack pulses then.
  - load while pending_vld=1 overwrites pending (latest wins); only one ack is issued.
  - load coincident with a commit: the old pending commits and the new data_in becomes pending (pending_vld stays 1).
- Mid-operation reset discards pending without an ack.
- Timing is constant regardless of mask, so brightness is uniform across digits.

Optional Feature:
SSD_LZ_BLANK_EN
- Defined: leading-zero suppression. Digit d (d = 3..1) is dark during ON when nibbles d..3 of display are all zero. Digit 0 is never suppressed. mask still applies. Slot timing is unchanged.
- Undefined: every digit with mask=1 is driven.

Decomposition:
- Package ssd_pkg:
  - state encoding constants (OFF, ON, BLANK)
  - ANODE_OFF = 4'b1111
  - NUM_DIGITS = 4
  - function digit_to_anode(2-bit) returning the active-low one-hot pattern
- Sub-module ssd_phase_timer: loadable down-counter (CNT_W bits) with a done flag. The FSM loads ON_CYC-1 or BLANK_CYC-1 into it.

Test Plan:
- ON_CYC=4, BLANK_CYC=2, mask=1111, load 16'h1234, en=1 -> anode 1110 for 4 cycles with nibble=4, then 1111 for 2 cycles, then 1101 with nibble=3; frame period 24 cycles; load_ack and frame_start coincide.
- mask=1010, display 16'hABCD -> slots 0 and 2 read anode=1111; slot 1 reads anode=1101 with nibble=C; slot 3 reads anode=0111 with nibble=A; slot timing unchanged.
- Load 16'h1111 then 16'h2222 in mid-frame -> exactly one load_ack at the next frame boundary; display=16'h2222.
- Drop en during digit-2 ON -> next cycle anode=1111 and control=0. Re-raise en -> digit 0 ON with a frame_start pulse.
- BLANK_CYC=0 -> anode steps 1110, 1101, 1011, 0111 with no 1111 gap.
- SSD_LZ_BLANK_EN defined, display 16'h0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0. Display 16'h0000 -> only digit 0 lit, showing 0.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package ssd_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } ssd_state_e;

  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam int         NUM_DIGITS = 4;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] digit_to_anode(input logic [1:0] digit);
    logic [3:0] pat;
    case (digit)
      2'd0:    pat = 4'b1110;
      2'd1:    pat = 4'b1101;
      2'd2:    pat = 4'b1011;
      2'd3:    pat = 4'b0111;
      default: pat = ANODE_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Display-side bundle of the scan controller: enable, load handshake, mask and scan outputs.
interface ssd_scan_ctrl_if;
  logic        en;
  logic [15:0] data_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  mask;
  logic [1:0]  control;
  logic [3:0]  nibble;
  logic [3:0]  anode;
  logic        frame_start;

  modport master (
    output en, data_in, load, mask,
    input  load_ack, control, nibble, anode, frame_start
  );

  modport slave (
    input  en, data_in, load, mask,
    output load_ack, control, nibble, anode, frame_start
  );
endinterface

// File: rtl/ssd_phase_timer.sv
// Loadable down-counter timing the ON and BLANK slots; done_o is high when the count reaches zero.
module ssd_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a load wins over a decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/ssd_scan_ctrl.sv
// 4-digit common-anode scan controller with blanking gap and frame-aligned double-buffered display word.
// Optional leading-zero suppression is enabled by defining SSD_LZ_BLANK_EN.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int ON_CYC    = 49744,
  parameter int BLANK_CYC = 256,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  ssd_scan_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] ON_LD    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK_CYC == 0) ? 0 : (BLANK_CYC - 1));

  ssd_state_e  state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  logic [15:0] display_q, display_d;
  logic [15:0] pending_q, pending_d;
  logic        pending_vld_q, pending_vld_d;
  logic [3:0]  anode_q, anode_d;
  logic [1:0]  control_q, control_d;
  logic [3:0]  nibble_q, nibble_d;
  logic        load_ack_q, load_ack_d;
  logic        frame_start_q, frame_start_d;

  logic             tmr_load_s;
  logic [CNT_W-1:0] tmr_val_s;
  logic             tmr_dec_s;
  logic             tmr_done_s;
  logic             frame_s;
  logic             commit_s;
  logic             lz_dark_s;
  logic             lit_s;

  ssd_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .dec_i      (tmr_dec_s),
    .done_o     (tmr_done_s)
  );

  // Scan sequencing: every slot entry reloads the timer, so a load marks a state transition.
  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = {CNT_W{1'b0}};
    tmr_dec_s  = 1'b0;
    if (!bus.en) begin
      state_d    = ST_OFF;
      digit_d    = 2'd0;
      tmr_load_s = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d    = ST_ON;
          digit_d    = 2'd0;
          tmr_load_s = 1'b1;
          tmr_val_s  = ON_LD;
        end
        ST_ON: begin
          if (tmr_done_s) begin
            tmr_load_s = 1'b1;
            if (BLANK_CYC == 0) begin
              digit_d   = digit_q + 2'd1;
              tmr_val_s = ON_LD;
            end else begin
              state_d   = ST_BLANK;
              tmr_val_s = BLANK_LD;
            end
          end else begin
            tmr_dec_s = 1'b1;
          end
        end
        ST_BLANK: begin
          if (tmr_done_s) begin
            state_d    = ST_ON;
            digit_d    = digit_q + 2'd1;
            tmr_load_s = 1'b1;
            tmr_val_s  = ON_LD;
          end else begin
            tmr_dec_s = 1'b1;
          end
        end
        default: begin
          state_d    = ST_OFF;
          digit_d    = 2'd0;
          tmr_load_s = 1'b1;
        end
      endcase
    end
  end

  assign frame_s  = tmr_load_s && (state_d == ST_ON) && (digit_d == 2'd0);
  assign commit_s = pending_vld_q && (frame_s || (state_q == ST_OFF));

  // Double buffer: a new load always lands in pending, even when the old pending commits.
  always_comb begin
    display_d     = display_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    if (commit_s) begin
      display_d     = pending_q;
      pending_vld_d = 1'b0;
    end else begin
      display_d = display_q;
    end
    if (bus.load) begin
      pending_d     = bus.data_in;
      pending_vld_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

`ifdef SSD_LZ_BLANK_EN
  // A digit is dark when it and every more significant nibble are zero; digit 0 always shows.
  always_comb begin
    lz_dark_s = 1'b0;
    case (digit_d)
      2'd3:    lz_dark_s = (display_d[15:12] == 4'h0);
      2'd2:    lz_dark_s = (display_d[15:8] == 8'h00);
      2'd1:    lz_dark_s = (display_d[15:4] == 12'h000);
      default: lz_dark_s = 1'b0;
    endcase
  end
`else
  assign lz_dark_s = 1'b0;
`endif

  // Output values are derived from next-state so they line up with the state register.
  always_comb begin
    lit_s         = (state_d == ST_ON) && bus.mask[digit_d] && !lz_dark_s;
    anode_d       = lit_s ? digit_to_anode(digit_d) : ANODE_OFF;
    control_d     = digit_d;
    nibble_d      = display_d[{digit_d, 2'b00} +: 4];
    load_ack_d    = commit_s;
    frame_start_d = frame_s;
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_OFF;
      digit_q       <= 2'd0;
      display_q     <= 16'h0000;
      pending_q     <= 16'h0000;
      pending_vld_q <= 1'b0;
      anode_q       <= ANODE_OFF;
      control_q     <= 2'd0;
      nibble_q      <= 4'h0;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      display_q     <= display_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      anode_q       <= anode_d;
      control_q     <= control_d;
      nibble_q      <= nibble_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.anode       = anode_q;
  assign bus.control     = control_q;
  assign bus.nibble      = nibble_q;
  assign bus.load_ack    = load_ack_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl: one instance with a blanking gap, one without.
module tb_ssd_scan_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  ssd_scan_ctrl_if ifa ();
  ssd_scan_ctrl_if ifb ();

  ssd_scan_ctrl #(.ON_CYC(4), .BLANK_CYC(2), .CNT_W(16)) dut_a (.CLK(CLK), .RST(RST), .bus(ifa));
  ssd_scan_ctrl #(.ON_CYC(4), .BLANK_CYC(0), .CNT_W(16)) dut_b (.CLK(CLK), .RST(RST), .bus(ifb));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected anode k cycles into a frame; slots are 4 ON cycles plus blank cycles.
  function automatic logic [3:0] exp_anode(input int k, input logic [3:0] m,
                                           input logic [15:0] disp, input int blank);
    int   s;
    int   d;
    bit   lit;
    s   = 4 + blank;
    d   = (k / s) % 4;
    lit = ((k % s) < 4) && (m[d] == 1'b1);
`ifdef SSD_LZ_BLANK_EN
    if (d != 0 && (disp >> (4 * d)) == 16'h0000) lit = 1'b0;
`endif
    return lit ? ~(4'b0001 << d) : 4'b1111;
  endfunction

  function automatic logic [3:0] exp_nib(input int k, input logic [15:0] disp, input int blank);
    int d;
    d = (k / (4 + blank)) % 4;
    return 4'((disp >> (4 * d)) & 16'h000F);
  endfunction

  // Checks one 24-cycle frame of dut_a starting at its frame_start; optionally loads two words mid-frame.
  task automatic frame_check(input logic [15:0] disp, input logic [3:0] m, input bit do_load,
                             input logic [15:0] d1, input logic [15:0] d2, input logic [3:0] m_next);
    for (int k = 0; k < 24; k++) begin
      if (do_load && k == 2) begin ifa.load = 1'b1; ifa.data_in = d1; end
      if (do_load && k == 3) ifa.data_in = d2;
      if (k == 4) ifa.load = 1'b0;
      if (k == 23) ifa.mask = m_next;
      chk("anode", 16'(ifa.anode), 16'(exp_anode(k, m, disp, 2)));
      chk("nibble", 16'(ifa.nibble), 16'(exp_nib(k, disp, 2)));
      chk("control", 16'(ifa.control), 16'((k / 6) % 4));
      chk("frame_start", 16'(ifa.frame_start), 16'(k == 0));
      if (k != 0) chk("ack_mid", 16'(ifa.load_ack), 16'h0);
      step();
    end
  endtask

  initial begin
    ifa.en = 1'b0; ifa.load = 1'b0; ifa.data_in = 16'h0000; ifa.mask = 4'b1111;
    ifb.en = 1'b0; ifb.load = 1'b0; ifb.data_in = 16'h0000; ifb.mask = 4'b1111;
    step(); step();
    RST = 1'b0;
    chk("rst_anode", 16'(ifa.anode), 16'h000F);
    chk("rst_control", 16'(ifa.control), 16'h0);
    chk("rst_nibble", 16'(ifa.nibble), 16'h0);
    chk("rst_ack", 16'(ifa.load_ack), 16'h0);
    chk("rst_fs", 16'(ifa.frame_start), 16'h0);

    // Load while dark: commits one cycle after capture.
    ifa.load = 1'b1; ifa.data_in = 16'h1234;
    step();
    ifa.load = 1'b0;
    chk("off_ack_early", 16'(ifa.load_ack), 16'h0);
    step();
    chk("off_ack", 16'(ifa.load_ack), 16'h1);
    chk("off_anode", 16'(ifa.anode), 16'h000F);
    chk("off_nibble", 16'(ifa.nibble), 16'h4);
    ifa.en = 1'b1;
    step();
    chk("start_fs", 16'(ifa.frame_start), 16'h1);
    chk("start_ack", 16'(ifa.load_ack), 16'h0);

    frame_check(16'h1234, 4'b1111, 1'b1, 16'h1111, 16'h2222, 4'b1111);
    chk("f2_fs", 16'(ifa.frame_start), 16'h1);
    chk("f2_ack", 16'(ifa.load_ack), 16'h1);
    frame_check(16'h2222, 4'b1111, 1'b1, 16'hABCD, 16'hABCD, 4'b1010);
    chk("f3_ack", 16'(ifa.load_ack), 16'h1);
    frame_check(16'hABCD, 4'b1010, 1'b1, 16'h0050, 16'h0050, 4'b1111);
    chk("f4_ack", 16'(ifa.load_ack), 16'h1);
    frame_check(16'h0050, 4'b1111, 1'b1, 16'h0000, 16'h0000, 4'b1111);
    chk("f5_ack", 16'(ifa.load_ack), 16'h1);
    frame_check(16'h0000, 4'b1111, 1'b0, 16'h0000, 16'h0000, 4'b1111);
    chk("f6_fs", 16'(ifa.frame_start), 16'h1);
    chk("f6_ack", 16'(ifa.load_ack), 16'h0);

    // Drop enable during digit 2 ON, then restart.
    for (int i = 0; i < 13; i++) step();
    chk("d2_control", 16'(ifa.control), 16'h2);
    ifa.en = 1'b0;
    step();
    chk("drop_anode", 16'(ifa.anode), 16'h000F);
    chk("drop_control", 16'(ifa.control), 16'h0);
    step();
    chk("drop_anode2", 16'(ifa.anode), 16'h000F);
    ifa.en = 1'b1;
    step();
    chk("re_fs", 16'(ifa.frame_start), 16'h1);
    chk("re_anode", 16'(ifa.anode), 16'h000E);
    chk("re_control", 16'(ifa.control), 16'h0);

    // No blank phase: anode walks through the digits with no all-off gap.
    ifb.load = 1'b1; ifb.data_in = 16'h4321;
    step();
    ifb.load = 1'b0;
    step();
    chk("b_ack", 16'(ifb.load_ack), 16'h1);
    ifb.en = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      chk("b_anode", 16'(ifb.anode), 16'(exp_anode(k, 4'b1111, 16'h4321, 0)));
      chk("b_nibble", 16'(ifb.nibble), 16'(exp_nib(k, 16'h4321, 0)));
      chk("b_fs", 16'(ifb.frame_start), 16'((k % 16) == 0));
      step();
    end

    // Reset with a pending word: it is discarded and never acknowledged.
    ifa.en = 1'b0; ifb.en = 1'b0;
    ifa.load = 1'b1; ifa.data_in = 16'h5555;
    step();
    ifa.load = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_drop_ack", 16'(ifa.load_ack), 16'h0);
      chk("rst_drop_nib", 16'(ifa.nibble), 16'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
